mole_button_rx: RTL
===================

// Module: mole_button_rx
// PURPOSE
//  Player-input end of the mole LED interface. Synchronises and debounces the four raw buttons,
//  turns each press into a single-cycle event and classifies it against the lit mole as hit or miss.
//  Feeds hit/miss pulses and a saturating hit count to the scoring logic.
//  Sits between the board buttons and the mole/score logic, on the same clock.
// PARAMETERS
//  NUM_BTN    4   buttons/holes; must equal the mole LED width
//  DB_CYCLES  16  consecutive stable cycles required to accept a new level (>=1)
//  CNT_W      6   hit counter width; counter saturates at 2**CNT_W-1
// PORTS
//  clk          in   1        system clock
//  reset        in   1        async active-low reset
//  button       in   NUM_BTN  raw buttons, active-high, asynchronous to clk
//  mole_onehot  in   NUM_BTN  currently lit mole(s); bit i = LED i
//  mole_valid   in   1        1 = a mole is on display; presses are classified only while high
//  round_clr    in   1        sync clear of hit_cnt and lockout
//  btn_level    out  NUM_BTN  debounced button levels
//  hit_pulse    out  1        1-cycle pulse: a press matched a lit mole
//  miss_pulse   out  1        1-cycle pulse: a press matched no lit mole
//  hit_idx      out  2        index of the button that produced the last hit
//  hit_cnt      out  CNT_W    saturating count of hits since reset/round_clr
// BEHAVIOUR
//  - Reset (reset=0, async): sync flops, btn_level, counters, hit_pulse, miss_pulse, hit_idx, hit_cnt -> 0.
//  - Sync: 2-flop synchroniser per button -> s[i].
//  - Debounce, per button: when s[i]==btn_level[i], counter=0.
//    When they differ, counter increments.
//    When counter reaches DB_CYCLES-1 while differing, btn_level[i]<=s[i] and counter=0.
//    Glitches shorter than DB_CYCLES are rejected. Counter width is $clog2(DB_CYCLES+1).
//  - Press event p[i] is the rising edge of btn_level[i], high for 1 cycle. Releases generate no event.
//  - Classification is registered; outputs appear the cycle after p:
//      mole_valid=0                       -> no pulse.
//      any p[i] & mole_onehot[i]          -> hit_pulse=1; hit_idx=lowest such i;
//                                            hit_cnt+1 (saturating).
//      else any p[i]                      -> miss_pulse=1.
//    hit_pulse and miss_pulse are never high in the same cycle. A simultaneous hit and wrong press count as a hit.
//  - Latency: a clean raw edge first sampled at edge N gives hit/miss_pulse high during cycle
//    N+DB_CYCLES+3, for exactly 1 cycle.
//  - round_clr: hit_cnt<=0 and lockout cleared next cycle. A hit in the same cycle is dropped (clear wins).
//    Debounce state is unaffected.
//  - A mid-operation reset aborts debounce. btn_level restarts at 0, so a button held through reset
//    registers as a new press after DB_CYCLES+2 cycles.
//  - hit_idx holds its value between hits.
// CONFIGURATION
//  HIT_LOCKOUT_EN defined:
//    After a hit, further hits are suppressed until mole_onehot changes value (registered compare)
//    or round_clr is asserted.
//    Suppressed presses on the lit button give no pulse. Wrong presses still give miss_pulse.
//  HIT_LOCKOUT_EN undefined: every qualifying press gives hit_pulse.
// STRUCTURE
//  - Shared package game_pkg: NUM_HOLES=4, default DB_CYCLES, SCORE_W=6, and the hole-index typedef
//    (2-bit), shared with the mole LED driver and score display.
//  - Sub-module btn_debounce (1 bit: synchroniser + counter + level), instantiated NUM_BTN times.
//  - Edge detection, classification, counter and lockout live in mole_button_rx.
// TESTING (DB_CYCLES=4 in bench)
//  1. mole_onehot=0100, mole_valid=1, button[2] held high -> one hit_pulse at cycle N+7;
//     hit_idx=2; hit_cnt 0->1.
//  2. button[2] bouncing 0/1 every 2 cycles for 12 cycles, then stable 1 -> btn_level[2] rises once;
//     exactly one hit_pulse.
//  3. mole_onehot=0001, press button[3] -> miss_pulse once; hit_cnt unchanged.
//  4. mole_valid=0, press any button -> no hit_pulse or miss_pulse; btn_level still follows the button.
//  5. 63 hits, then one more hit -> hit_cnt stays 63.
//     round_clr together with a hit -> hit_cnt=0.
//  6. HIT_LOCKOUT_EN, mole 0010 unchanged, press button[1] twice -> 1 hit_pulse.
//     Change mole to 1000, press button[3] -> 2nd hit.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game constants and the hole-index type used by the mole LED driver, score display and button receiver.
// Pure declarations plus one combinational helper; no latency, no flow control.
package game_pkg;

    localparam int NUM_HOLES     = 4;
    localparam int DB_CYCLES_DEF = 16;
    localparam int SCORE_W       = 6;

    typedef logic [1:0] hole_idx_t;

    // Lowest set bit wins so that simultaneous hits report a deterministic hole.
    function automatic hole_idx_t lowest_hole(input logic [NUM_HOLES-1:0] v);
        hole_idx_t r;
        r = '0;
        for (int i = NUM_HOLES - 1; i >= 0; i--) begin
            if (v[i]) begin
                r = hole_idx_t'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mole_button_rx_if.sv
// Bundle between the player buttons / mole logic and the button receiver.
// Plain wires; latency and flow belong to the modules on either side.
interface mole_button_rx_if
    import game_pkg::*;
#(
    parameter int NUM_BTN = NUM_HOLES,
    parameter int CNT_W   = SCORE_W
) ();

    logic [NUM_BTN-1:0] button;
    logic [NUM_BTN-1:0] mole_onehot;
    logic               mole_valid;
    logic               round_clr;
    logic [NUM_BTN-1:0] btn_level;
    logic               hit_pulse;
    logic               miss_pulse;
    hole_idx_t          hit_idx;
    logic [CNT_W-1:0]   hit_cnt;

    modport master (
        output button, mole_onehot, mole_valid, round_clr,
        input  btn_level, hit_pulse, miss_pulse, hit_idx, hit_cnt
    );

    modport slave (
        input  button, mole_onehot, mole_valid, round_clr,
        output btn_level, hit_pulse, miss_pulse, hit_idx, hit_cnt
    );

endinterface

// File: rtl/btn_debounce.sv
// One button: 2-flop synchroniser, then a level that only moves after DB_CYCLES consecutive differing samples.
// Latency: level follows a clean raw edge DB_CYCLES+2 clocks after it is first sampled.
// No backpressure; free-running every clock.
module btn_debounce #(
    parameter int DB_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic level
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;

    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        cnt_d   = '0;
        level_d = level_q;
        // Any sample agreeing with the current level restarts the count, so short glitches never land.
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/mole_button_rx.sv
// Debounces the player buttons, turns presses into events and scores them against the lit mole (hit/miss, hit count).
// Latency: pulse one clock after the debounced rising edge; HIT_LOCKOUT_EN adds per-mole hit lockout.
// No backpressure: pulses are single-cycle and must be consumed when they appear.
module mole_button_rx
    import game_pkg::*;
#(
    parameter int NUM_BTN   = NUM_HOLES,
    parameter int DB_CYCLES = DB_CYCLES_DEF,
    parameter int CNT_W     = SCORE_W
) (
    input  logic             clk,
    input  logic             reset,
    mole_button_rx_if.slave  bus
);

    logic [NUM_BTN-1:0] level;
    logic [NUM_BTN-1:0] level_dly_q, level_dly_d;
    logic               hit_pulse_q, hit_pulse_d;
    logic               miss_pulse_q, miss_pulse_d;
    hole_idx_t          hit_idx_q, hit_idx_d;
    logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
    logic [NUM_BTN-1:0] press;
    logic [NUM_BTN-1:0] hit_vec;
    logic               hit_any;
    logic               press_any;
`ifdef HIT_LOCKOUT_EN
    logic               lockout_q, lockout_d;
    logic [NUM_BTN-1:0] mole_prev_q, mole_prev_d;
    logic               mole_chg;
    logic               hit_ok;
`endif

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
        btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
            .clk     (clk),
            .reset   (reset),
            .btn_raw (bus.button[i]),
            .level   (level[i])
        );
    end

    always_comb begin
        level_dly_d  = level;
        press        = level & ~level_dly_q;
        hit_vec      = press & bus.mole_onehot;
        hit_any      = bus.mole_valid & (|hit_vec);
        press_any    = bus.mole_valid & (|press);
        hit_pulse_d  = 1'b0;
        miss_pulse_d = 1'b0;
`ifdef HIT_LOCKOUT_EN
        mole_prev_d  = bus.mole_onehot;
        mole_chg     = (bus.mole_onehot != mole_prev_q);
        // A new mole pattern releases the lock in the same cycle it is seen.
        hit_ok       = hit_any & ~(lockout_q & ~mole_chg);
        hit_pulse_d  = hit_ok;
        if (hit_any) begin
            miss_pulse_d = ~hit_ok & bus.mole_valid & (|(press & ~bus.mole_onehot));
        end else begin
            miss_pulse_d = press_any;
        end
        lockout_d = lockout_q;
        if (bus.round_clr) begin
            lockout_d = 1'b0;
        end else if (hit_ok) begin
            lockout_d = 1'b1;
        end else if (mole_chg) begin
            lockout_d = 1'b0;
        end
`else
        hit_pulse_d  = hit_any;
        miss_pulse_d = press_any & ~hit_any;
`endif
        hit_idx_d = hit_pulse_d ? lowest_hole(hit_vec) : hit_idx_q;
        hit_cnt_d = hit_cnt_q;
        if (bus.round_clr) begin
            hit_cnt_d = '0;
        end else if (hit_pulse_d && (hit_cnt_q != '1)) begin
            hit_cnt_d = hit_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level_dly_q  <= '0;
            hit_pulse_q  <= 1'b0;
            miss_pulse_q <= 1'b0;
            hit_idx_q    <= '0;
            hit_cnt_q    <= '0;
`ifdef HIT_LOCKOUT_EN
            lockout_q    <= 1'b0;
            mole_prev_q  <= '0;
`endif
        end else begin
            level_dly_q  <= level_dly_d;
            hit_pulse_q  <= hit_pulse_d;
            miss_pulse_q <= miss_pulse_d;
            hit_idx_q    <= hit_idx_d;
            hit_cnt_q    <= hit_cnt_d;
`ifdef HIT_LOCKOUT_EN
            lockout_q    <= lockout_d;
            mole_prev_q  <= mole_prev_d;
`endif
        end
    end

    assign bus.btn_level  = level;
    assign bus.hit_pulse  = hit_pulse_q;
    assign bus.miss_pulse = miss_pulse_q;
    assign bus.hit_idx    = hit_idx_q;
    assign bus.hit_cnt    = hit_cnt_q;

endmodule
